lsh_cluster_core: RTL and testbench

LSH_CLUSTER_CORE -- requirements
Module: lsh_cluster_core

---
 rtl/lsh_cluster_core.sv | 117 +++++++++++
 tb/tb_lsh_cluster_core.sv | 183 ++++++++++++++++++
 2 files changed

// File: rtl/lsh_cluster_core.sv
// lsh_cluster_core: LSH cache-line classifier; hashes a line, votes clusters through a signature memory, reports the argmax cluster.
// Ports: clk/reset (async, active-high); linha_cache/endereco with in_valid/in_ready request handshake;
// out_cluster/out_score/out_hit with out_valid/out_ready result handshake; cfg_we/cfg_addr/cfg_data signature-memory writes (IDLE only).
module lsh_cluster_core #(
  parameter int LINE_BITS = 512,
  parameter int ADDR_BITS = 64,
  parameter int HASH_BITS = 4,
  parameter int N_HASH    = 8,
  parameter int N_CLUSTER = 16,
  parameter int MIN_SCORE = 4,
  localparam int SW = $clog2(N_HASH + 1),
  localparam int CW = $clog2(N_CLUSTER),
  localparam int LW = $clog2(N_HASH * (2 ** HASH_BITS))
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [LINE_BITS-1:0] linha_cache,
  input  logic [ADDR_BITS-1:0] endereco,
  input  logic                 in_valid,
  output logic                 in_ready,
  output logic [CW-1:0]        out_cluster,
  output logic [SW-1:0]        out_score,
  output logic                 out_hit,
  output logic                 out_valid,
  input  logic                 out_ready,
  input  logic                 cfg_we,
  input  logic [LW-1:0]        cfg_addr,
  input  logic [N_CLUSTER-1:0] cfg_data
);
  localparam int HW = $clog2(N_HASH);
  localparam int NJ = LINE_BITS / (HASH_BITS * N_HASH);
  typedef enum logic [2:0] {IDLE, HASH, LOOKUP, ARGMAX, DONE} state_t;
  state_t state;
  logic [N_CLUSTER-1:0] primeira_matriz [N_HASH * (2 ** HASH_BITS)];
  logic [LINE_BITS-1:0] line_r;
  logic [HASH_BITS-1:0] addr_r;
  logic [HASH_BITS-1:0] hash_r [N_HASH];
  logic [HASH_BITS-1:0] hash_c [N_HASH];
  logic [SW-1:0]        score [N_CLUSTER];
  logic [HW-1:0]        hidx;
  logic [CW-1:0]        cidx;
  logic [CW-1:0]        best_c, next_c;
  logic [SW-1:0]        best_s, next_s;
  logic [N_CLUSTER-1:0] rd;
  logic                 take;
  logic                 unused_addr;
  assign unused_addr = ^endereco[ADDR_BITS-1:HASH_BITS];
  assign in_ready  = state == IDLE;
  assign out_valid = state == DONE;
  // Hash h folds every chunk whose index is congruent to h mod N_HASH, seeded with the low address bits.
  always_comb begin
    for (int h = 0; h < N_HASH; h++) begin
      hash_c[h] = addr_r;
      for (int j = 0; j < NJ; j++) hash_c[h] = hash_c[h] ^ line_r[(j*N_HASH+h)*HASH_BITS +: HASH_BITS];
    end
  end
  // Entry index h*2^HASH_BITS + hash_h is just the concatenation of the two fields.
  assign rd     = primeira_matriz[LW'({hidx, hash_r[hidx]})];
  assign take   = score[cidx] > best_s;
  assign next_c = take ? cidx : best_c;
  assign next_s = take ? score[cidx] : best_s;
  always_ff @(posedge clk) begin
    if (state == IDLE && in_valid) begin
      line_r <= linha_cache;
      addr_r <= endereco[HASH_BITS-1:0];
    end
    if (state == HASH) hash_r <= hash_c;
    if (state == IDLE && cfg_we) primeira_matriz[cfg_addr] <= cfg_data;
  end
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state       <= IDLE;
      hidx        <= '0;
      cidx        <= '0;
      best_c      <= '0;
      best_s      <= '0;
      out_cluster <= '0;
      out_score   <= '0;
      out_hit     <= 1'b0;
      for (int c = 0; c < N_CLUSTER; c++) score[c] <= '0;
    end else begin
      case (state)
        IDLE: if (in_valid) begin
          for (int c = 0; c < N_CLUSTER; c++) score[c] <= '0;
          state <= HASH;
        end
        HASH: begin
          hidx  <= '0;
          state <= LOOKUP;
        end
        LOOKUP: begin
          for (int c = 0; c < N_CLUSTER; c++) if (rd[c]) score[c] <= score[c] + SW'(1);
          hidx <= hidx + HW'(1);
          if (hidx == HW'(N_HASH - 1)) begin
            cidx   <= '0;
            best_c <= '0;
            best_s <= '0;
            state  <= ARGMAX;
          end
        end
        ARGMAX: begin
          best_c <= next_c;
          best_s <= next_s;
          cidx   <= cidx + CW'(1);
          if (cidx == CW'(N_CLUSTER - 1)) begin
            out_cluster <= next_c;
            out_score   <= next_s;
            out_hit     <= next_s >= SW'(MIN_SCORE);
            state       <= DONE;
          end
        end
        DONE: if (out_ready) state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_lsh_cluster_core.sv
// tb_lsh_cluster_core: directed bench with a behavioural classification model and a per-cycle result comparator.
module tb_lsh_cluster_core;
  localparam int LB = 512, AB = 64, NH = 8, NC = 16, MS = 4, LAT = 1 + NH + NC;
  logic clk, reset;
  logic [LB-1:0] linha_cache;
  logic [AB-1:0] endereco;
  logic in_valid, in_ready, out_hit, out_valid, out_ready, cfg_we;
  logic [3:0] out_cluster, out_score;
  logic [6:0] cfg_addr;
  logic [15:0] cfg_data;
  lsh_cluster_core dut (
    .clk(clk), .reset(reset), .linha_cache(linha_cache), .endereco(endereco),
    .in_valid(in_valid), .in_ready(in_ready), .out_cluster(out_cluster), .out_score(out_score),
    .out_hit(out_hit), .out_valid(out_valid), .out_ready(out_ready),
    .cfg_we(cfg_we), .cfg_addr(cfg_addr), .cfg_data(cfg_data));
  initial clk = 0;
  always #5 clk = ~clk;
  int checks = 0, errors = 0;
  bit [15:0] mm [128];
  int exp_c, exp_s;
  bit exp_h, cmp_en;
  task automatic chk(string nm, longint act, longint exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    end
  endtask
  function automatic void model(input bit [LB-1:0] l, input bit [AB-1:0] a, output int c, output int s, output bit hit);
    int sc [NC];
    bit [3:0] hv;
    bit [15:0] e;
    for (int i = 0; i < NC; i++) sc[i] = 0;
    for (int h = 0; h < NH; h++) begin
      hv = a[3:0];
      for (int k = 0; k < LB / 4; k++) if (k % NH == h) hv ^= l[k*4 +: 4];
      e = mm[h*16 + hv];
      for (int i = 0; i < NC; i++) if (e[i]) sc[i]++;
    end
    c = 0;
    for (int i = 1; i < NC; i++) if (sc[i] > sc[c]) c = i;
    s = sc[c];
    hit = s >= MS;
  endfunction
  always @(negedge clk) if (cmp_en && out_valid) begin
    chk("cluster", out_cluster, exp_c);
    chk("score", out_score, exp_s);
    chk("hit", out_hit, exp_h);
    chk("in_ready_in_done", in_ready, 0);
  end
  task automatic cfg_write(int a, bit [15:0] d, bit apply);
    @(negedge clk);
    cfg_we = 1; cfg_addr = 7'(a); cfg_data = d;
    @(posedge clk);
    #1 cfg_we = 0;
    if (apply) mm[a] = d;
  endtask
  task automatic clear_mem();
    for (int i = 0; i < 128; i++) cfg_write(i, 16'h0, 1);
  endtask
  task automatic issue(bit [LB-1:0] l, bit [AB-1:0] a, bit we, int wa, bit [15:0] wd);
    @(negedge clk);
    if (we) begin
      cfg_we = 1; cfg_addr = 7'(wa); cfg_data = wd; mm[wa] = wd;
    end
    model(l, a, exp_c, exp_s, exp_h);
    linha_cache = l; endereco = a; in_valid = 1; cmp_en = 1;
    chk("in_ready_idle", in_ready, 1);
    @(posedge clk);
    #1 in_valid = 0; cfg_we = 0;
    chk("in_ready_busy", in_ready, 0);
  endtask
  task automatic wait_done();
    int n = 0;
    while (!out_valid && n < 200) begin
      @(posedge clk);
      #1 n++;
    end
    chk("latency", n, LAT);
  endtask
  task automatic release_out();
    @(negedge clk) out_ready = 1;
    @(posedge clk);
    #1 out_ready = 0;
    chk("valid_after_release", out_valid, 0);
    chk("ready_after_release", in_ready, 1);
  endtask
  task automatic run(bit [LB-1:0] l, bit [AB-1:0] a);
    issue(l, a, 0, 0, 0);
    wait_done();
    release_out();
  endtask
  task automatic pin(string nm, int c, int s, bit h);
    chk({nm, "_model_c"}, exp_c, c);
    chk({nm, "_model_s"}, exp_s, s);
    chk({nm, "_model_h"}, exp_h, h);
    chk({nm, "_dut_c"}, out_cluster, c);
    chk({nm, "_dut_s"}, out_score, s);
    chk({nm, "_dut_h"}, out_hit, h);
  endtask
  bit [LB-1:0] rl, cl;
  bit [AB-1:0] ra, ca;
  int hc, hs;
  bit hh, seen;
  initial begin
    reset = 1; in_valid = 0; out_ready = 0; cfg_we = 0; cfg_addr = 0; cfg_data = 0;
    linha_cache = 0; endereco = 0; cmp_en = 0;
    #1;
    chk("rst_in_ready", in_ready, 1);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_cluster", out_cluster, 0);
    chk("rst_score", out_score, 0);
    chk("rst_hit", out_hit, 0);
    repeat (2) @(posedge clk);
    @(negedge clk) reset = 0;
    clear_mem();
    for (int h = 0; h < NH; h++) cfg_write(h*16, 16'h0008, 1);
    run(0, 0);
    pin("single", 3, 8, 1);
    for (int h = 0; h < NH; h++) cfg_write(h*16, 16'h0024, 1);
    run(0, 0);
    pin("tie", 2, 8, 1);
    clear_mem();
    for (int i = 0; i < 16; i++) rl[i*32 +: 32] = $urandom;
    ra = {$urandom, $urandom};
    run(rl, ra);
    pin("zero", 0, 0, 0);
    for (int h = 0; h < 3; h++) cfg_write(h*16, 16'h0080, 1);
    run(0, 0);
    pin("partial", 7, 3, 0);
    clear_mem();
    cfg_write(0, 16'h0001, 1);
    for (int h = 1; h < NH; h++) cfg_write(h*16 + 3, 16'h0002, 1);
    cl = 0; cl[3:0] = 4'h5; cl[35:32] = 4'h6;
    ca = 64'hABCD_0000_1234_5673;
    run(cl, ca);
    pin("chunks", 1, 7, 1);
    issue(cl, ca, 0, 0, 0);
    wait_done();
    hc = out_cluster; hs = out_score; hh = out_hit;
    for (int i = 0; i < 10; i++) begin
      if (i == 5) cfg_write(0, 16'hFFFF, 0);
      else begin
        @(posedge clk);
        #1;
      end
      chk("hold_valid", out_valid, 1);
      chk("hold_ready", in_ready, 0);
      chk("hold_cluster", out_cluster, hc);
      chk("hold_score", out_score, hs);
      chk("hold_hit", out_hit, hh);
    end
    release_out();
    run(cl, ca);
    pin("nowrite", 1, 7, 1);
    for (int i = 0; i < 128; i++) cfg_write(i, 16'($urandom), 1);
    for (int t = 0; t < 4; t++) begin
      for (int i = 0; i < 16; i++) rl[i*32 +: 32] = $urandom;
      ra = {$urandom, $urandom};
      run(rl, ra);
    end
    for (int h = 0; h < NH; h++) cfg_write(h*16, 16'h0, 1);
    issue(0, 0, 1, 16, 16'h4000);
    wait_done();
    release_out();
    chk("same_edge_score", out_score, 1);
    chk("same_edge_cluster", out_cluster, 14);
    issue(cl, ca, 0, 0, 0);
    repeat (5) @(posedge clk);
    #1 reset = 1;
    #1;
    chk("abort_valid", out_valid, 0);
    chk("abort_ready", in_ready, 1);
    @(negedge clk) reset = 0;
    seen = 0;
    repeat (40) @(negedge clk) if (out_valid) seen = 1;
    chk("abort_no_result", seen, 0);
    run(cl, ca);
    repeat (2) @(posedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
